ws2812_bit_receiver: RTL and testbench

Decodes a WS2812B-style one-wire NRZ waveform back into 24-bit GRB pixel words.
- Measures each high pulse against a threshold to recover bits.
- Detects the latch/reset gap to mark frame end.
- Used for loopback checking of the LED transmit chain on the BASYS 3 (100 MHz clk), and as a software-visible monitor of a downstream strip's data line.

---
 rtl/ws2812_bit_receiver.sv | 163 ++++++++++++++++
 tb/tb_ws2812_bit_receiver.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_bit_receiver.sv
// WS2812B NRZ line decoder: recovers 24-bit GRB words (first bit in bit 23) and latch gaps.
// Define WS2812_RX_PASSTHRU_EN to capture only the first word per frame and forward the rest on dout.
module ws2812_bit_receiver #(
  parameter int T_MIN_HIGH = 10,
  parameter int T_THRESH   = 60,
  parameter int T_MAX_HIGH = 200,
  parameter int T_RESET    = 5000,
  parameter int CNT_W      = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        din,
  output logic [23:0] pixel,
  output logic        pixel_valid,
  output logic        frame_end,
  output logic        bit_err,
  output logic        busy,
  output logic        dout
);

  localparam logic [1:0] S_SYNC = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_LOW  = 2'd3;

  localparam logic [CNT_W-1:0] MIN_HI = CNT_W'(T_MIN_HIGH);
  localparam logic [CNT_W-1:0] THRESH = CNT_W'(T_THRESH);
  localparam logic [CNT_W-1:0] MAX_HI = CNT_W'(T_MAX_HIGH);
  localparam logic [CNT_W-1:0] GAP_M1 = CNT_W'(T_RESET - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic             din_m, din_s, din_q;
  logic             rise, fall;
  logic [1:0]       state;
  logic [CNT_W-1:0] hcnt, lcnt;
  logic [4:0]       bcnt;
  logic [23:0]      shreg;
  logic             word_done;
`ifdef WS2812_RX_PASSTHRU_EN
  logic             captured;
`endif

  assign rise = din_s & ~din_q;
  assign fall = ~din_s & din_q;
  assign busy = (state == S_HIGH) || (state == S_LOW);

`ifdef WS2812_RX_PASSTHRU_EN
  assign dout = captured & din_s;
`else
  assign dout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      din_m       <= 1'b0;
      din_s       <= 1'b0;
      din_q       <= 1'b0;
      state       <= S_SYNC;
      hcnt        <= '0;
      lcnt        <= '0;
      bcnt        <= '0;
      shreg       <= '0;
      word_done   <= 1'b0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      frame_end   <= 1'b0;
      bit_err     <= 1'b0;
`ifdef WS2812_RX_PASSTHRU_EN
      captured    <= 1'b0;
`endif
    end else begin
      din_m       <= din;
      din_s       <= din_m;
      din_q       <= din_s;
      pixel_valid <= 1'b0;
      frame_end   <= 1'b0;
      bit_err     <= 1'b0;
      word_done   <= 1'b0;

      // Publish the word one cycle after its 24th bit landed in shreg.
      if (word_done) begin
        bcnt <= '0;
`ifdef WS2812_RX_PASSTHRU_EN
        if (!captured) begin
          pixel       <= shreg;
          pixel_valid <= 1'b1;
          captured    <= 1'b1;
        end
`else
        pixel       <= shreg;
        pixel_valid <= 1'b1;
`endif
      end

      case (state)
        S_SYNC: begin
          if (lcnt == GAP_M1) begin
            state <= S_IDLE;
            lcnt  <= '0;
`ifdef WS2812_RX_PASSTHRU_EN
            captured <= 1'b0;
`endif
          end else if (din_s) begin
            lcnt <= '0;
          end else begin
            lcnt <= lcnt + ONE;
          end
        end

        S_IDLE: begin
          if (rise) begin
            state <= S_HIGH;
            hcnt  <= ONE;
          end
        end

        S_HIGH: begin
          if (fall) begin
            if (hcnt < MIN_HI) begin
              bit_err <= 1'b1;
              bcnt    <= '0;
              lcnt    <= '0;
              state   <= S_SYNC;
            end else begin
              shreg <= {shreg[22:0], (hcnt >= THRESH)};
              bcnt  <= bcnt + 5'd1;
              if (bcnt == 5'd23) word_done <= 1'b1;
              lcnt  <= ONE;
              state <= S_LOW;
            end
          end else if (hcnt == MAX_HI) begin
            // Line stuck high: resynchronise rather than guess at bit boundaries.
            bit_err <= 1'b1;
            bcnt    <= '0;
            lcnt    <= '0;
            state   <= S_SYNC;
          end else begin
            hcnt <= hcnt + ONE;
          end
        end

        default: begin
          if (rise) begin
            state <= S_HIGH;
            hcnt  <= ONE;
          end else if (lcnt == GAP_M1) begin
            frame_end <= 1'b1;
            bit_err   <= (bcnt != 5'd0);
            bcnt      <= '0;
            lcnt      <= '0;
            state     <= S_IDLE;
`ifdef WS2812_RX_PASSTHRU_EN
            captured  <= 1'b0;
`endif
          end else begin
            lcnt <= lcnt + ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_bit_receiver.sv
// Directed + randomized bench for ws2812_bit_receiver with a frame-level bit-list model.
module tb_ws2812_bit_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        din = 1'b0;
  logic [23:0] pixel;
  logic        pixel_valid, frame_end, bit_err, busy, dout;

  ws2812_bit_receiver dut (
    .clk(clk), .reset(reset), .din(din), .pixel(pixel), .pixel_valid(pixel_valid),
    .frame_end(frame_end), .bit_err(bit_err), .busy(busy), .dout(dout)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  int cyc = 0;
  logic [1:0] din_hist = 2'b00;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    din_hist <= {din_hist[0], din};
  end

  // Output monitor, sampled on the falling edge.
  int pv_cnt = 0, fe_cnt = 0, err_cnt = 0, fe_err_cnt = 0;
  int pv_cyc = 0, fe_cyc = 0, err_cyc = 0;
  int dout_bad = 0, dout_any = 0;
  bit dout_chk = 1'b0;
  logic [23:0] got_pix[$];

  always @(negedge clk) begin
    if (pixel_valid) begin
      got_pix.push_back(pixel);
      pv_cnt = pv_cnt + 1;
      pv_cyc = cyc;
    end
    if (frame_end) begin
      fe_cnt = fe_cnt + 1;
      fe_cyc = cyc;
    end
    if (bit_err) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if (frame_end && bit_err) fe_err_cnt = fe_err_cnt + 1;
    if (dout) dout_any = dout_any + 1;
    if (dout_chk && (dout !== din_hist[1])) dout_bad = dout_bad + 1;
  end

  // Reference model: the bits of the current frame and what they must produce.
  bit          fbits[$];
  logic [23:0] exp_pix[$];
  logic [23:0] exp_pixel = '0;
  int exp_pv = 0, exp_fe = 0, exp_err = 0, exp_fe_err = 0;
  int last_fall = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input bit b, input int hi, input int lo);
    din = 1'b1;
    repeat (hi) @(negedge clk);
    din = 1'b0;
    last_fall = cyc;
    repeat (lo) @(negedge clk);
    fbits.push_back(b);
  endtask

  task automatic send_word_fixed(input logic [23:0] w, input int hi1, input int lo1,
                                 input int hi0, input int lo0);
    for (int i = 23; i >= 0; i--) begin
      if (w[i]) send_bit(1'b1, hi1, lo1);
      else      send_bit(1'b0, hi0, lo0);
    end
  endtask

  task automatic send_rand_bits(input int n);
    for (int i = 0; i < n; i++) begin
      bit b;
      b = 1'($urandom());
      send_bit(b, b ? int'($urandom_range(100, 62)) : int'($urandom_range(55, 12)),
               int'($urandom_range(40, 10)));
    end
  endtask

  task automatic gap(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic end_frame();
    int n;
    int ng;
    gap(5010);
    n  = fbits.size();
    ng = n / 24;
`ifdef WS2812_RX_PASSTHRU_EN
    if (ng > 1) ng = 1;
`endif
    for (int g = 0; g < ng; g++) begin
      logic [23:0] w;
      w = '0;
      for (int k = 0; k < 24; k++) w = {w[22:0], fbits[g*24 + k]};
      exp_pix.push_back(w);
      exp_pixel = w;
      exp_pv++;
    end
    if (n > 0) exp_fe++;
    if ((n % 24) != 0) begin
      exp_err++;
      exp_fe_err++;
    end
    fbits.delete();
  endtask

  task automatic compare(input string tag);
    check({tag, "_npv"}, pv_cnt, exp_pv);
    check({tag, "_nfe"}, fe_cnt, exp_fe);
    check({tag, "_nerr"}, err_cnt, exp_err);
    check({tag, "_fe_err"}, fe_err_cnt, exp_fe_err);
    check({tag, "_pixel"}, {8'h0, pixel}, {8'h0, exp_pixel});
    while (exp_pix.size() > 0 && got_pix.size() > 0)
      check({tag, "_word"}, {8'h0, got_pix.pop_front()}, {8'h0, exp_pix.pop_front()});
    check({tag, "_leftover"}, exp_pix.size() + got_pix.size(), 0);
    exp_pix.delete();
    got_pix.delete();
  endtask

  initial begin
    int lf;
    int lr;
    repeat (3) @(negedge clk);
    check("rst_pixel", {8'h0, pixel}, 32'h0);
    check("rst_pv", pixel_valid, 0);
    check("rst_fe", frame_end, 0);
    check("rst_err", bit_err, 0);
    check("rst_busy", busy, 0);
    check("rst_dout", dout, 0);
    reset = 1'b0;
    gap(5010);
    check("idle_busy", busy, 0);

    // Nominal word with canonical timing, plus output latencies.
    send_word_fixed(24'hFF00A5, 80, 40, 35, 85);
    check("t1_busy", busy, 1);
    lf = last_fall;
    end_frame();
    compare("t1");
    check("t1_lat_pv", pv_cyc - lf, 4);
    check("t1_lat_fe", fe_cyc - lf, 5002);

    // Two words in one frame; with passthrough the second must appear on dout.
    send_word_fixed(24'h123456, 65, 15, 20, 30);
    dout_chk = 1'b1;
    send_word_fixed(24'hABCDEF, 65, 15, 20, 30);
    dout_chk = 1'b0;
    end_frame();
    compare("t2");
`ifdef WS2812_RX_PASSTHRU_EN
    check("t2_dout_copy", dout_bad, 0);
    check("t2_dout_active", (dout_any != 0), 1);
`endif

    // Threshold edges: 60 high is a one, 59 high is a zero.
    send_bit(1'b1, 60, 15);
    for (int i = 0; i < 22; i++) send_bit(1'b0, 59, 15);
    send_bit(1'b1, 60, 15);
    end_frame();
    compare("t3");

    for (int f = 0; f < 2; f++) begin
      send_rand_bits(24 * (f + 1));
      end_frame();
      compare("rnd");
    end

    // Glitch mid-word, then decode resumes only after a full gap.
    send_rand_bits(10);
    din = 1'b1;
    repeat (5) @(negedge clk);
    gap(50);
    fbits.delete();
    exp_err++;
    check("t4_glitch_err", err_cnt, exp_err);
    check("t4_sync_busy", busy, 0);
    send_rand_bits(8);
    fbits.delete();
    check("t4_nodecode", pv_cnt, exp_pv);
    gap(5010);
    send_rand_bits(34);
    end_frame();
    compare("t4");

    // Stuck-high line.
    send_rand_bits(3);
    din = 1'b1;
    lr = cyc;
    repeat (250) @(negedge clk);
    gap(20);
    fbits.delete();
    exp_err++;
    check("t6_stuck_err", err_cnt, exp_err);
    check("t6_stuck_lat", err_cyc - lr, 203);
    send_rand_bits(8);
    fbits.delete();
    check("t6_nodecode", pv_cnt, exp_pv);
    gap(5010);

    // Reset in the middle of a word.
    send_rand_bits(12);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    fbits.delete();
    exp_pixel = '0;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_err", err_cnt, exp_err);
    check("t6_rst_pixel", {8'h0, pixel}, 32'h0);
    send_rand_bits(8);
    fbits.delete();
    gap(5010);
    send_rand_bits(24);
    end_frame();
    compare("t6");

`ifndef WS2812_RX_PASSTHRU_EN
    check("dout_tied", dout_any, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
